// File: rtl/fsk_bit_slicer.sv
// FSK bit slicer: hysteresis slicer on the averager output plus an
// asynchronous-serial framing FSM (1 start, 8 data LSB first, 1 stop).
// Completed bytes are offered on a one-entry valid/ready output slot.
module fsk_bit_slicer #(
   parameter int THRESH          = 1024,
   parameter int SAMPLES_PER_BIT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] phase,
   input  logic [4:0]  sample_rate,
   input  logic [15:0] filtered,
   output logic        slice,
   output logic [7:0]  data_out,
   output logic        data_valid,
   input  logic        data_ready,
   output logic        frame_err,
   output logic        overrun
);

   localparam int CW = $clog2(SAMPLES_PER_BIT);
   // START decides on the strobe where the counter would reach half-bit - 1,
   // i.e. while it still holds half-bit - 2.
   localparam logic [CW-1:0] HALF_LAST = CW'(SAMPLES_PER_BIT / 2 - 2);
   localparam logic [CW-1:0] BIT_LAST  = CW'(SAMPLES_PER_BIT - 1);
   localparam logic signed [16:0] TH_POS = 17'(THRESH);
   localparam logic signed [16:0] TH_NEG = -TH_POS;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_q, state_d;
   logic            prev_q, prev_d;
   logic            slice_q, slice_d;
   logic [CW-1:0]   scnt_q, scnt_d;
   logic [2:0]      bcnt_q, bcnt_d;
   logic [7:0]      sreg_q, sreg_d;
   logic [7:0]      dout_q, dout_d;
   logic            dv_q, dv_d;
   logic            fe_q, fe_d;
   logic            ov_q, ov_d;

   logic            stb;
   logic            s;
   logic            hs;
   logic            byte_done;
   logic signed [16:0] filt_x;

   // Strobe detect and hysteresis decision; exact +/-THRESH holds the slice.
   always_comb begin
      stb    = phase[sample_rate] ^ prev_q;
      filt_x = {filtered[15], filtered};
      if (filt_x > TH_POS)      s = 1'b1;
      else if (filt_x < TH_NEG) s = 1'b0;
      else                      s = slice_q;
   end

   // Framing FSM and output slot; everything except the handshake waits for a strobe.
   always_comb begin
      state_d   = state_q;
      prev_d    = prev_q;
      slice_d   = slice_q;
      scnt_d    = scnt_q;
      bcnt_d    = bcnt_q;
      sreg_d    = sreg_q;
      dout_d    = dout_q;
      dv_d      = dv_q;
      fe_d      = 1'b0;
      ov_d      = 1'b0;
      byte_done = 1'b0;
      hs        = dv_q & data_ready;

      if (stb) begin
         prev_d  = phase[sample_rate];
         slice_d = s;
         case (state_q)
            IDLE: begin
               // A start edge is a mark-to-space transition of the decision.
               if (slice_q && !s) begin
                  state_d = START;
                  scnt_d  = '0;
               end
            end
            START: begin
               if (scnt_q == HALF_LAST) begin
                  scnt_d  = '0;
                  bcnt_d  = 3'd0;
                  state_d = s ? IDLE : DATA;
               end else begin
                  scnt_d = scnt_q + CW'(1);
               end
            end
            DATA: begin
               if (scnt_q == BIT_LAST) begin
                  sreg_d[bcnt_q] = s;
                  scnt_d         = '0;
                  if (bcnt_q == 3'd7) state_d = STOP;
                  else                bcnt_d  = bcnt_q + 3'd1;
               end else begin
                  scnt_d = scnt_q + CW'(1);
               end
            end
            STOP: begin
               if (scnt_q == BIT_LAST) begin
                  scnt_d  = '0;
                  state_d = IDLE;
                  if (s) byte_done = 1'b1;
                  else   fe_d      = 1'b1;
               end else begin
                  scnt_d = scnt_q + CW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // A slot being emptied this cycle can take the new byte directly.
      if (byte_done && (!dv_q || hs)) begin
         dout_d = sreg_q;
         dv_d   = 1'b1;
      end else if (byte_done) begin
         ov_d = 1'b1;
      end else if (hs) begin
         dv_d = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         prev_q  <= 1'b0;
         slice_q <= 1'b1;
         scnt_q  <= '0;
         bcnt_q  <= 3'd0;
         sreg_q  <= 8'h00;
         dout_q  <= 8'h00;
         dv_q    <= 1'b0;
         fe_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         slice_q <= slice_d;
         scnt_q  <= scnt_d;
         bcnt_q  <= bcnt_d;
         sreg_q  <= sreg_d;
         dout_q  <= dout_d;
         dv_q    <= dv_d;
         fe_q    <= fe_d;
         ov_q    <= ov_d;
      end
   end

   assign slice      = slice_q;
   assign data_out   = dout_q;
   assign data_valid = dv_q;
   assign frame_err  = fe_q;
   assign overrun    = ov_q;

endmodule

// File: tb/tb_fsk_bit_slicer.sv
// Bench for fsk_bit_slicer: builds serial frames as per-strobe amplitude
// samples, knows from construction which strobe samples each stop bit, and
// predicts slice/slot/pulse outputs every clock.
module tb_fsk_bit_slicer;

   localparam int TH       = 1024;
   localparam int SPB      = 16;
   localparam int FRAME    = SPB * 10;
   localparam int STOP_IDX = SPB / 2 + 9 * SPB - 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] phase;
   logic [4:0]  sample_rate;
   logic [15:0] filtered;
   logic        data_ready;
   logic        slice;
   logic [7:0]  data_out;
   logic        data_valid;
   logic        frame_err;
   logic        overrun;

   always #5 clk = ~clk;

   fsk_bit_slicer #(.THRESH(TH), .SAMPLES_PER_BIT(SPB)) dut (
      .clk(clk), .rst(rst), .phase(phase), .sample_rate(sample_rate),
      .filtered(filtered), .slice(slice), .data_out(data_out),
      .data_valid(data_valid), .data_ready(data_ready),
      .frame_err(frame_err), .overrun(overrun)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Expected outputs after the most recent edge.
   bit       m_slice, m_dv, m_fe, m_ov;
   logic [7:0] m_do;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic check_outs();
      chk("slice", 32'(slice), 32'(m_slice));
      chk("data_valid", 32'(data_valid), 32'(m_dv));
      chk("data_out", 32'(data_out), 32'(m_do));
      chk("frame_err", 32'(frame_err), 32'(m_fe));
      chk("overrun", 32'(overrun), 32'(m_ov));
   endtask

   task automatic model_reset();
      m_slice = 1'b1; m_dv = 1'b0; m_fe = 1'b0; m_ov = 1'b0; m_do = 8'h00;
   endtask

   // One clock: optional strobe with amplitude lvl; evb/evf flag that this
   // strobe is a stop sample completing byte b / failing framing.
   task automatic step(input bit stb, input int lvl, input bit rdy,
                       input bit evb, input bit evf, input logic [7:0] b);
      bit hs, load;
      filtered   = 16'(lvl);
      data_ready = rdy;
      if (stb) phase = phase + (32'd1 << sample_rate);
      @(posedge clk); #1;
      hs   = m_dv && rdy;
      load = stb && evb && (!m_dv || hs);
      m_fe = stb && evf;
      m_ov = stb && evb && !load;
      if (stb) begin
         if (lvl > TH)       m_slice = 1'b1;
         else if (lvl < -TH) m_slice = 1'b0;
      end
      if (load)    begin m_do = b; m_dv = 1'b1; end
      else if (hs) m_dv = 1'b0;
      check_outs();
   endtask

   // Out-of-band level of the requested polarity, or (if noisy) sometimes an
   // in-band value including the exact +/-TH boundaries.
   function automatic int lvl_of(input bit v, input bit noisy);
      int mag;
      if (noisy && ($urandom % 4 == 0)) return int'($urandom_range(0, 2 * TH)) - TH;
      case ($urandom % 8)
         0:       mag = TH + 1;
         1:       mag = 32767;
         2:       mag = v ? 2000 : 32768;
         default: mag = int'($urandom_range(TH + 1, 20000));
      endcase
      return v ? mag : -mag;
   endfunction

   function automatic bit get_rdy(input int mode, input bit at_stop);
      case (mode)
         0:       return 1'b0;
         1:       return ($urandom % 3 == 0);
         default: return at_stop;
      endcase
   endfunction

   // Mark gap; first sample always clearly mark so the next start can arm.
   task automatic gap(input int n, input int mode);
      for (int j = 0; j < n; j++) step(1'b1, lvl_of(1'b1, j != 0), get_rdy(mode, 1'b0), 1'b0, 1'b0, 8'h00);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int mode,
                             input bit stalls, input int abort_at);
      for (int i = 0; i < FRAME; i++) begin
         int bi = i / SPB;
         int k  = i % SPB;
         bit v;
         if (i == abort_at) return;
         v = (bi == 0) ? 1'b0 : (bi <= 8) ? b[bi-1] : stop_ok;
         if (stalls)
            for (int t = 0; t < 3; t++)
               if ($urandom % 4 == 0)
                  step(1'b0, int'($urandom_range(0, 65535)) - 32768, get_rdy(mode, 1'b0), 1'b0, 1'b0, b);
         step(1'b1, lvl_of(v, k != 0), get_rdy(mode, i == STOP_IDX),
              (i == STOP_IDX) && stop_ok, (i == STOP_IDX) && !stop_ok, b);
      end
   endtask

   task automatic drain();
      step(1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      bit [4:0] nsr;
      rst = 1'b1; phase = 32'd0; sample_rate = 5'd0; filtered = 16'(-2000); data_ready = 1'b0;
      model_reset();

      // Reset held with space input and toggling strobes.
      for (int i = 0; i < 4; i++) begin
         phase = phase + 32'd1;
         @(posedge clk); #1;
         check_outs();
      end
      phase = 32'd0;
      rst   = 1'b0;

      // First strobe after release starts frame 0x55; held until ready.
      send_frame(8'h55, 1'b1, 0, 1'b0, -1);
      chk("byte_55", 32'(data_out), 32'h55);
      for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00);
      drain();
      chk("valid_clr", 32'(data_valid), 32'd0);

      // In-band input never moves the slice.
      for (int i = 0; i < 12; i++)
         step(1'b1, (i % 2) ? 500 : -500, 1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b1, -TH, 1'b0, 1'b0, 1'b0, 8'h00);

      // False start: 3 space strobes then mark.
      gap(2, 0);
      for (int i = 0; i < 3; i++) step(1'b1, -2000, 1'b0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 13; i++) step(1'b1, 2000, 1'b0, 1'b0, 1'b0, 8'h00);

      // Framing error, boundary levels while slice is space, then 0x3C.
      gap(2, 0);
      send_frame(8'hA5, 1'b0, 0, 1'b0, -1);
      step(1'b1, TH, 1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b1, 500, 1'b0, 1'b0, 1'b0, 8'h00);
      gap(2, 0);
      send_frame(8'h3C, 1'b1, 0, 1'b0, -1);
      chk("byte_3c", 32'(data_out), 32'h3C);
      drain();

      // Overrun with a full slot.
      gap(1, 0);
      send_frame(8'hA3, 1'b1, 0, 1'b0, -1);
      send_frame(8'h3C, 1'b1, 0, 1'b0, -1);
      chk("ovr_keep", 32'(data_out), 32'hA3);
      drain();

      // Slot emptied on the same cycle the next byte completes.
      gap(1, 0);
      send_frame(8'hA3, 1'b1, 0, 1'b0, -1);
      send_frame(8'h3C, 1'b1, 2, 1'b0, -1);
      chk("hs_load", 32'(data_out), 32'h3C);
      drain();

      // Reset during data bit 4, then frame 0x0F.
      gap(2, 0);
      send_frame(8'h5A, 1'b1, 0, 1'b0, SPB + 4 * SPB + 5);
      rst = 1'b1;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check_outs();
      end
      phase[sample_rate] = 1'b0;
      rst = 1'b0;
      gap(3, 0);
      send_frame(8'h0F, 1'b1, 0, 1'b0, -1);
      chk("byte_0f", 32'(data_out), 32'h0F);

      // Randomized frames, stalls, handshakes and strobe-rate changes.
      for (int f = 0; f < 30; f++) begin
         if ($urandom % 4 == 0) begin
            nsr = 5'($urandom % 4);
            phase[nsr]  = phase[sample_rate];
            sample_rate = nsr;
         end
         gap(1 + int'($urandom % 3), 1);
         send_frame(8'($urandom), ($urandom % 5) != 0, 1, 1'b1, -1);
      end
      for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
